// File: rtl/serial_demux_1ton_pkg.sv
// Shared definitions for the serial 1-to-N deserializer.
// FSM state encodings and the legal frame-width range.
package serial_demux_1ton_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_demux_1ton_bit_lane_decoder.sv
// Combinational 1-to-N demux: one-hot write enable for lane sel.
// Ports: sel, en, d in; we[WIDTH-1:0] one-hot (zero when !en), d_out = d.
module bit_lane_decoder
    import serial_demux_1ton_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [$clog2(WIDTH)-1:0] sel,
    input  logic                     en,
    input  logic                     d,
    output logic [WIDTH-1:0]         we,
    output logic                     d_out
);

    localparam int CW = $clog2(WIDTH);

    always_comb begin
        we = '0;
        for (int k = 0; k < WIDTH; k++) begin
            we[k] = en && (sel == CW'(k));
        end
    end

    assign d_out = d;

endmodule

// File: rtl/serial_demux_1ton.sv
// Serial-to-parallel deserializer: steers each valid bit into a word lane.
// Ports: clk, rst_n, din, din_valid, frame_start in; dout, dout_valid, busy, frame_err out.
module serial_demux_1ton
    import serial_demux_1ton_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("serial_demux_1ton: WIDTH out of range 2..32");
        end
    endgenerate

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [WIDTH-1:0] buf_q;
    logic [WIDTH-1:0] buf_d;
    logic [WIDTH-1:0] we;
    logic [CW-1:0]   lane;
    logic [CW-1:0]   sel;
    logic            wr_en;
    logic            restart;
    logic            abort;
    logic            done;
    logic            lane_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        restart = 1'b0;
        abort   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (din_valid && frame_start) begin
                    wr_en   = 1'b1;
                    restart = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (din_valid) begin
                    wr_en = 1'b1;
                    if (frame_start) begin
                        restart = 1'b1;
                        abort   = 1'b1;
                        cnt_d   = CW'(1);
                    end else if (cnt_q == LAST) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A new frame always writes lane 0; physical bit depends on order.
    assign lane = restart ? '0 : cnt_q;
    assign sel  = LSB_FIRST ? lane : (LAST - lane);

    bit_lane_decoder #(
        .WIDTH (WIDTH)
    ) u_dec (
        .sel   (sel),
        .en    (wr_en),
        .d     (din),
        .we    (we),
        .d_out (lane_d)
    );

    // Restart clears stale bits so an aborted frame cannot leak through.
    always_comb begin
        buf_d = restart ? '0 : buf_q;
        buf_d = (buf_d & ~we) | (we & {WIDTH{lane_d}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            buf_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            dout_valid <= done;
            frame_err  <= abort;
            if (done) begin
                dout <= buf_d;
            end
        end
    end

    assign busy = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_serial_demux_1ton.sv
// Bench for serial_demux_1ton: LSB-first and MSB-first instances
// driven in parallel and compared against a frame-level model.
module tb_serial_demux_1ton;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic [W-1:0] dout_l;
    logic [W-1:0] dout_m;
    logic         dv_l, dv_m;
    logic         busy_l, busy_m;
    logic         err_l, err_m;

    always #5 clk = ~clk;

    serial_demux_1ton #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .dout        (dout_l),
        .dout_valid  (dv_l),
        .busy        (busy_l),
        .frame_err   (err_l)
    );

    serial_demux_1ton #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .dout        (dout_m),
        .dout_valid  (dv_m),
        .busy        (busy_m),
        .frame_err   (err_m)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level model: list of bits received so far in the open frame.
    bit           m_open;
    bit           m_bits[$];
    logic [W-1:0] m_dout_l, m_dout_m;
    bit           m_dv, m_err;

    int cyc = 0;
    int dv_cnt = 0;
    int err_cnt = 0;
    int dv_cyc[$];
    logic [W-1:0] dv_word[$];

    function automatic void model_reset();
        m_open = 0;
        m_bits.delete();
        m_dout_l = '0;
        m_dout_m = '0;
        m_dv = 0;
        m_err = 0;
    endfunction

    function automatic void model_edge();
        m_dv  = 0;
        m_err = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!din_valid) return;
        if (frame_start) begin
            if (m_open) m_err = 1;
            m_bits.delete();
            m_bits.push_back(din);
            m_open = 1;
        end else if (m_open) begin
            m_bits.push_back(din);
            if (m_bits.size() == W) begin
                for (int k = 0; k < W; k++) begin
                    m_dout_l[k]       = m_bits[k];
                    m_dout_m[W-1-k]   = m_bits[k];
                end
                m_dv = 1;
                m_open = 0;
                m_bits.delete();
            end
        end
    endfunction

    task automatic compare();
        check("dout_lsb", 32'(dout_l), 32'(m_dout_l));
        check("dout_msb", 32'(dout_m), 32'(m_dout_m));
        check("dv_lsb", 32'(dv_l), 32'(m_dv));
        check("dv_msb", 32'(dv_m), 32'(m_dv));
        check("busy_lsb", 32'(busy_l), 32'(m_open));
        check("busy_msb", 32'(busy_m), 32'(m_open));
        check("err_lsb", 32'(err_l), 32'(m_err));
        check("err_msb", 32'(err_m), 32'(m_err));
        check("dv_err_excl", 32'(dv_l & err_l), 32'(0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        cyc++;
        if (dv_l) begin
            dv_cnt++;
            dv_cyc.push_back(cyc);
            dv_word.push_back(dout_l);
        end
        if (err_l) err_cnt++;
    endtask

    task automatic send(input logic b, input logic fs);
        din = b;
        frame_start = fs;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic gap();
        din_valid = 1'b0;
        frame_start = 1'b0;
        din = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) send(w[k], k == 0);
    endtask

    logic [W-1:0] pat;
    int d0, e0;

    initial begin
        model_reset();
        pat = 8'b0100_1101;

        // Reset held with random traffic
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 1'($urandom_range(0, 1));
            din_valid = 1'($urandom_range(0, 1));
            frame_start = 1'($urandom_range(0, 1));
            step();
        end
        din_valid = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gap();

        // Basic frame: bits 1,0,1,1,0,0,1,0
        send_word(pat);
        check("t2_dout_lsb", 32'(dout_l), 32'h4D);
        check("t2_dout_msb", 32'(dout_m), 32'hB2);
        d0 = dv_cnt;
        gap();
        check("t2_one_pulse", 32'(dv_cnt - d0), 32'd0);

        // Same bits with gaps between every bit
        d0 = dv_cnt;
        for (int k = 0; k < W; k++) begin
            send(pat[k], k == 0);
            check("t3_busy", 32'(busy_m), 32'(k != W - 1));
            gap();
        end
        check("t3_dout_msb", 32'(dout_m), 32'hB2);
        check("t3_pulses", 32'(dv_cnt - d0), 32'd1);

        // Early frame_start: 3 bits, restart bit, 7 more
        d0 = dv_cnt;
        e0 = err_cnt;
        for (int k = 0; k < 3; k++) send(1'($urandom_range(0, 1)), k == 0);
        send(1'b1, 1'b1);
        for (int k = 0; k < 7; k++) send(1'($urandom_range(0, 1)), 1'b0);
        gap();
        check("t4_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("t4_dv_pulses", 32'(dv_cnt - d0), 32'd1);

        // Back-to-back frames
        e0 = err_cnt;
        dv_cyc.delete();
        dv_word.delete();
        send_word(8'hA5);
        send_word(8'h3C);
        gap();
        check("t5_pulses", 32'(dv_cyc.size()), 32'd2);
        if (dv_cyc.size() == 2) begin
            check("t5_spacing", 32'(dv_cyc[1] - dv_cyc[0]), 32'd8);
            check("t5_word0", 32'(dv_word[0]), 32'hA5);
            check("t5_word1", 32'(dv_word[1]), 32'h3C);
        end
        check("t5_no_err", 32'(err_cnt - e0), 32'd0);

        // Async reset between edges after 4 bits
        for (int k = 0; k < 4; k++) send(1'b0, k == 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hFF);
        check("t6_dout", 32'(dout_l), 32'hFF);
        gap();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            din = 1'($urandom_range(0, 1));
            din_valid = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
